cam64_frame_sequencer: RTL and testbench

//   Frame timing controller for the dummy 64x64 camera. On a start request it

---
 rtl/cam64_frame_sequencer.sv | 129 ++++++++++++
 tb/tb_cam64_frame_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cam64_frame_sequencer.sv
// Frame timing controller for the dummy 64x64 camera: walks ACTIVE/HBLANK lines,
// then VBLANK, single-shot or back-to-back, with registered HREF/VSYNC/X/Y outputs.
module cam64_frame_sequencer #(
  parameter int H_ACTIVE = 64,
  parameter int H_BLANK  = 16,
  parameter int V_ACTIVE = 64,
  parameter int V_BLANK  = 8,
  parameter int CW       = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          CONTINUOUS,
  input  logic          ABORT,
  output logic          BUSY,
  output logic          VSYNC,
  output logic          HREF,
  output logic          PIX_VALID,
  output logic [CW-1:0] PIX_X,
  output logic [CW-1:0] PIX_Y,
  output logic          LINE_DONE,
  output logic          FRAME_DONE,
  output logic [7:0]    FRAME_CNT
);

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

  localparam logic [CW-1:0] X_LAST  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] Y_LAST  = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] HB_LAST = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] VB_LAST = CW'(V_BLANK - 1);

  state_t        st, st_n;
  logic [CW-1:0] bcnt, bcnt_n, x_n, y_n;
  logic [7:0]    fcnt_n;
  logic          busy_n, vsync_n, href_n, ld_n, fd_n;

  always_comb begin
    st_n   = st;
    x_n    = PIX_X;
    y_n    = PIX_Y;
    bcnt_n = bcnt;
    fcnt_n = FRAME_CNT;
    case (st)
      IDLE: begin
        if (START) begin
          st_n = ACTIVE;
          x_n  = '0;
          y_n  = '0;
        end
      end
      ACTIVE: begin
        if (PIX_X == X_LAST) begin
          st_n   = HBLANK;
          bcnt_n = '0;
        end else begin
          x_n = PIX_X + 1'b1;
        end
      end
      HBLANK: begin
        if (bcnt != HB_LAST) begin
          bcnt_n = bcnt + 1'b1;
        end else if (PIX_Y == Y_LAST) begin
          st_n   = VBLANK;
          bcnt_n = '0;
        end else begin
          st_n = ACTIVE;
          x_n  = '0;
          y_n  = PIX_Y + 1'b1;
        end
      end
      VBLANK: begin
        if (bcnt != VB_LAST) begin
          bcnt_n = bcnt + 1'b1;
        end else begin
          fcnt_n = FRAME_CNT + 1'b1;
          bcnt_n = '0;
          x_n    = '0;
          y_n    = '0;
          st_n   = CONTINUOUS ? ACTIVE : IDLE;
        end
      end
      default: st_n = IDLE;
    endcase
    // Abort overrides every transition above, including START and CONTINUOUS.
    if (ABORT) begin
      st_n   = IDLE;
      x_n    = '0;
      y_n    = '0;
      bcnt_n = '0;
      fcnt_n = FRAME_CNT;
    end
    // Outputs are decoded from the next state so they line up with it once registered.
    busy_n  = (st_n != IDLE);
    vsync_n = (st_n == ACTIVE) || (st_n == HBLANK);
    href_n  = (st_n == ACTIVE);
    ld_n    = (st_n == ACTIVE) && (x_n == X_LAST);
    fd_n    = (st_n == VBLANK) && (bcnt_n == VB_LAST);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st         <= IDLE;
      bcnt       <= '0;
      PIX_X      <= '0;
      PIX_Y      <= '0;
      FRAME_CNT  <= '0;
      BUSY       <= 1'b0;
      VSYNC      <= 1'b0;
      HREF       <= 1'b0;
      PIX_VALID  <= 1'b0;
      LINE_DONE  <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      st         <= st_n;
      bcnt       <= bcnt_n;
      PIX_X      <= x_n;
      PIX_Y      <= y_n;
      FRAME_CNT  <= fcnt_n;
      BUSY       <= busy_n;
      VSYNC      <= vsync_n;
      HREF       <= href_n;
      PIX_VALID  <= href_n;
      LINE_DONE  <= ld_n;
      FRAME_DONE <= fd_n;
    end
  end

endmodule

// File: tb/tb_cam64_frame_sequencer.sv
// Bench: default-size sequencer under directed steps, plus a tiny 2x2 instance under
// random START/CONTINUOUS/ABORT; both compared every cycle against a frame-position model.
module tb_cam64_frame_sequencer;
  localparam int CW = 8;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic a_start, a_cont, a_abort, b_start, b_cont, b_abort;
  logic a_busy, a_vsync, a_href, a_pv, a_ld, a_fd;
  logic b_busy, b_vsync, b_href, b_pv, b_ld, b_fd;
  logic [CW-1:0] a_x, a_y, b_x, b_y;
  logic [7:0] a_fcnt, b_fcnt;

  cam64_frame_sequencer u_a (
    .CLK(CLK), .RST(RST), .START(a_start), .CONTINUOUS(a_cont), .ABORT(a_abort),
    .BUSY(a_busy), .VSYNC(a_vsync), .HREF(a_href), .PIX_VALID(a_pv),
    .PIX_X(a_x), .PIX_Y(a_y), .LINE_DONE(a_ld), .FRAME_DONE(a_fd), .FRAME_CNT(a_fcnt));

  cam64_frame_sequencer #(.H_ACTIVE(2), .H_BLANK(1), .V_ACTIVE(2), .V_BLANK(1), .CW(CW)) u_b (
    .CLK(CLK), .RST(RST), .START(b_start), .CONTINUOUS(b_cont), .ABORT(b_abort),
    .BUSY(b_busy), .VSYNC(b_vsync), .HREF(b_href), .PIX_VALID(b_pv),
    .PIX_X(b_x), .PIX_Y(b_y), .LINE_DONE(b_ld), .FRAME_DONE(b_fd), .FRAME_CNT(b_fcnt));

  logic [29:0] obs_a, obs_b;
  assign obs_a = {a_busy, a_vsync, a_href, a_pv, a_ld, a_fd, a_fcnt, a_x, a_y};
  assign obs_b = {b_busy, b_vsync, b_href, b_pv, b_ld, b_fd, b_fcnt, b_x, b_y};

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a frame is just a position 0..period-1; line/column come from division.
  int mh[2]  = '{64, 2};
  int mhb[2] = '{16, 1};
  int mv[2]  = '{64, 2};
  int mvb[2] = '{8, 1};
  bit m_run[2];
  int m_pos[2];
  logic [7:0] m_fc[2];

  int cyc = 0;
  int a_vcnt = 0, a_fdcnt = 0, a_fd_cyc = 0, a_fs_cyc = 0, a_gap_ok = 0;
  bit b_wrap_seen = 0;

  function automatic int period(int k);
    return mv[k] * (mh[k] + mhb[k]) + mvb[k];
  endfunction

  task automatic model_step(int k, logic s, logic c, logic a);
    if (a) begin
      m_run[k] = 0; m_pos[k] = 0;
    end else if (!m_run[k]) begin
      if (s) begin m_run[k] = 1; m_pos[k] = 0; end
    end else if (m_pos[k] == period(k) - 1) begin
      m_fc[k] = m_fc[k] + 8'd1; m_pos[k] = 0; m_run[k] = c;
    end else begin
      m_pos[k]++;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin m_run[k] = 0; m_pos[k] = 0; m_fc[k] = 8'd0; end
  endtask

  task automatic check(int k);
    int L, line, col;
    logic vs, hr, ld, fd;
    logic [7:0] ex, ey;
    bit vb;
    logic [29:0] exp_v, got;
    L = mh[k] + mhb[k];
    line = m_pos[k] / L;
    col = m_pos[k] % L;
    vs = 0; hr = 0; ld = 0; fd = 0; ex = 0; ey = 0; vb = 0;
    if (m_run[k]) begin
      if (line < mv[k]) begin
        vs = 1;
        hr = (col < mh[k]);
        ex = 8'(hr ? col : mh[k] - 1);
        ey = 8'(line);
        ld = (col == mh[k] - 1);
      end else begin
        vb = 1;
        fd = (m_pos[k] == period(k) - 1);
      end
    end
    exp_v = {m_run[k], vs, hr, hr, ld, fd, m_fc[k], ex, ey};
    got = (k == 0) ? obs_a : obs_b;
    if (vb) got[15:0] = 16'd0;  // X/Y are not defined during vertical blanking
    vectors++;
    assert (got === exp_v) else begin
      miscompares++;
      $error("FAIL outputs inst%0d cyc%0d got %h expected %h", k, cyc, got, exp_v);
    end
  endtask

  task automatic chk(string tag, int got, int expv);
    vectors++;
    assert (got === expv) else begin
      miscompares++;
      $error("FAIL %s got %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic tick();
    logic [7:0] prev_fc;
    prev_fc = m_fc[1];
    @(posedge CLK);
    model_step(0, a_start, a_cont, a_abort);
    model_step(1, b_start, b_cont, b_abort);
    cyc++;
    @(negedge CLK);
    check(0);
    check(1);
    if (a_pv) a_vcnt++;
    if (a_pv && a_x == 0 && a_y == 0) begin
      a_fs_cyc = cyc;
      if (a_fdcnt > 0 && a_fd_cyc == cyc - 1) a_gap_ok++;
    end
    if (a_fd) begin a_fdcnt++; a_fd_cyc = cyc; end
    if (prev_fc == 8'd255 && m_fc[1] == 8'd0 && b_fcnt == 8'd0) b_wrap_seen = 1;
    b_start = 1'($urandom_range(0, 1));
    b_cont  = ($urandom_range(0, 3) != 0);
    b_abort = ($urandom_range(0, 63) == 0);
  endtask

  task automatic run_until_idle(int budget);
    int n;
    n = 0;
    do begin tick(); n++; end while (a_busy && n < budget);
    chk("idle_timeout", int'(a_busy), 0);
  endtask

  initial begin
    int fc0, fd0, n;
    RST = 1'b1;
    a_start = 0; a_cont = 0; a_abort = 0;
    b_start = 0; b_cont = 0; b_abort = 0;
    model_reset();
    repeat (2) @(negedge CLK);
    check(0); check(1);
    RST = 1'b0;
    tick();

    // Single frame; a stray START mid-frame must not disturb it.
    a_vcnt = 0;
    a_start = 1; tick(); a_start = 0;
    chk("first_pv", int'(a_pv), 1);
    chk("first_xy", int'({a_x, a_y}), 0);
    repeat (100) tick();
    a_start = 1; tick(); a_start = 0;
    run_until_idle(6000);
    chk("frame_done_offset", a_fd_cyc - a_fs_cyc, 5127);
    chk("valid_pixels_1", a_vcnt, 4096);
    chk("frame_cnt_1", int'(a_fcnt), 1);

    // Three back-to-back frames.
    a_vcnt = 0; a_fdcnt = 0; a_gap_ok = 0;
    a_cont = 1; a_start = 1; tick(); a_start = 0;
    n = 0;
    while (!(a_fdcnt >= 2 && !a_fd) && n < 12000) begin tick(); n++; end
    chk("cont_timeout", int'(a_fdcnt >= 2), 1);
    a_cont = 0;
    run_until_idle(6000);
    chk("frame_cnt_4", int'(a_fcnt), 4);
    chk("valid_pixels_3", a_vcnt, 3 * 4096);
    chk("no_gap", a_gap_ok, 2);
    chk("frame_done_3", a_fdcnt, 3);

    // Abort at Y=10, X=20, then START+ABORT together, then a clean frame.
    a_start = 1; tick(); a_start = 0;
    n = 0;
    while (!(a_pv && a_x == 20 && a_y == 10) && n < 2000) begin tick(); n++; end
    chk("abort_point", int'({a_x, a_y}), int'({8'd20, 8'd10}));
    fc0 = a_fcnt; fd0 = a_fdcnt;
    a_abort = 1; tick(); a_abort = 0;
    chk("abort_busy", int'(a_busy), 0);
    chk("abort_xy", int'({a_x, a_y}), 0);
    a_start = 1; a_abort = 1; tick(); a_start = 0; a_abort = 0;
    chk("start_abort_busy", int'(a_busy), 0);
    repeat (3) tick();
    a_start = 1; tick(); a_start = 0;
    run_until_idle(6000);
    chk("abort_fcnt", int'(a_fcnt), fc0 + 1);
    chk("abort_fd", a_fdcnt, fd0 + 1);

    // Asynchronous reset mid-frame.
    a_start = 1; tick(); a_start = 0;
    repeat (50) tick();
    #2 RST = 1'b1;
    #1 model_reset();
    check(0); check(1);
    b_start = 0; b_cont = 0; b_abort = 0;
    @(negedge CLK);
    RST = 1'b0;
    tick();

    chk("b_wrap_255_to_0", int'(b_wrap_seen), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
